// File: rtl/evt_sched_pkg.sv
// rtl/evt_sched_pkg.sv - shared types and helpers for the delayed event-trigger scheduler
// Purpose: slot record type, default widths and bit-vector helpers used by evt_timer_sched.
// Ports: none (package).
// Build option: EVT_SCHED_CANCEL_EN (see evt_timer_sched) does not affect this file.
package evt_sched_pkg;

  localparam int PKG_NUM_EVT = 4;
  localparam int PKG_EVT_W   = (PKG_NUM_EVT > 1) ? $clog2(PKG_NUM_EVT) : 1;
  localparam int PKG_DELAY_W = 8;

  // Helpers operate on a fixed-width vector so loop bounds stay constant;
  // callers pad unused upper bits (ones for lowest_free, zeros for popcount).
  localparam int MAX_SLOTS = 32;

  typedef struct packed {
    logic                   vld;
    logic [PKG_EVT_W-1:0]   evt;
    logic [PKG_DELAY_W-1:0] cnt;
  } slot_t;

  // Index of the lowest clear bit; 0 when none is clear (caller gates with a free flag).
  function automatic int lowest_free(input logic [MAX_SLOTS-1:0] vld);
    lowest_free = 0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (!vld[i]) lowest_free = i;
    end
  endfunction

  function automatic int popcount(input logic [MAX_SLOTS-1:0] v);
    popcount = 0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (v[i]) popcount = popcount + 1;
    end
  endfunction

endpackage

// File: rtl/evt_sched_rr_arb.sv
// rtl/evt_sched_rr_arb.sv - round-robin grant over a request vector
// Purpose: one-hot grant to the first asserted request at or after ptr (wrapping),
//          plus the pointer value that follows that grantee.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   PTR_W    search start index (always < NUM_REQ)
//   grant    out  NUM_REQ  one-hot grant, zero when no request
//   next_ptr out  PTR_W    grantee+1 mod NUM_REQ, or ptr when no grant
module evt_sched_rr_arb
  import evt_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/evt_timer_sched.sv
// rtl/evt_timer_sched.sv - timer table that pulses event lines after per-request delays
// Purpose: NUM_REQ requesters post (event, delay) pairs; each accepted pair occupies a
//          slot, counts down, and pulses evt_fire[evt] for one cycle D+2 cycles after
//          its handshake.
// Build option: EVT_SCHED_CANCEL_EN adds cancel_valid/cancel_evt, which free every
//          occupied slot holding cancel_evt (and suppress its fire) at that edge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is combinational, one-hot)
//   req_evt, req_delay       packed per-requester event id and delay
//   evt_fire                 registered one-cycle pulses, one per event
//   busy, slots_used         registered occupancy status (post-edge state)
//   cancel_valid, cancel_evt optional cancel request
module evt_timer_sched
  import evt_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_SLOTS = 4,
  // Slot records use the package widths; NUM_EVT/DELAY_W must match them.
  parameter  int NUM_EVT   = PKG_NUM_EVT,
  parameter  int DELAY_W   = PKG_DELAY_W,
  localparam int EVT_W     = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1,
  localparam int USED_W    = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*EVT_W-1:0]   req_evt,
  input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
`ifdef EVT_SCHED_CANCEL_EN
  input  logic                       cancel_valid,
  input  logic [EVT_W-1:0]           cancel_evt,
`endif
  output logic [NUM_EVT-1:0]         evt_fire,
  output logic                       busy,
  output logic [USED_W-1:0]          slots_used
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  slot_t                slots     [NUM_SLOTS];
  slot_t                slots_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] vld_cur;
  logic [NUM_SLOTS-1:0] vld_nxt;
  logic [NUM_SLOTS-1:0] cancel_hit;
  logic [MAX_SLOTS-1:0] vld_pad;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic                 free_exists;
  logic                 hs;
  logic [SLOT_W-1:0]    alloc_idx;
  logic [EVT_W-1:0]     sel_evt;
  logic [DELAY_W-1:0]   sel_delay;
  logic [NUM_EVT-1:0]   fire_nxt;

  evt_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_nxt)
  );

  // Unused helper bits read as occupied so they are never picked as free.
  always_comb begin
    vld_cur = '0;
    vld_pad = '1;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      vld_cur[s] = slots[s].vld;
      vld_pad[s] = slots[s].vld;
    end
  end

  // Free-slot test looks only at registered state, so an expiry this cycle
  // cannot open a slot until the following cycle.
  assign free_exists = ~&vld_cur;
  assign req_ready   = free_exists ? grant : '0;
  assign hs          = |req_ready;
  assign alloc_idx   = SLOT_W'(lowest_free(vld_pad));

  always_comb begin
    sel_evt   = '0;
    sel_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_evt   = req_evt[i*EVT_W +: EVT_W];
        sel_delay = req_delay[i*DELAY_W +: DELAY_W];
      end
    end
  end

`ifdef EVT_SCHED_CANCEL_EN
  always_comb begin
    cancel_hit = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      cancel_hit[s] = cancel_valid && slots[s].vld && (slots[s].evt == cancel_evt);
    end
  end
`else
  assign cancel_hit = '0;
`endif

  // Countdown, expiry and allocation. The allocated slot was free in registered
  // state, so it never collides with a slot being counted, fired or cancelled;
  // a same-cycle request for a cancelled event therefore survives.
  always_comb begin
    fire_nxt = '0;
    vld_nxt  = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slots_nxt[s] = slots[s];
      if (slots[s].vld) begin
        if (cancel_hit[s]) begin
          slots_nxt[s].vld = 1'b0;
        end else if (slots[s].cnt == '0) begin
          fire_nxt[slots[s].evt] = 1'b1;
          slots_nxt[s].vld       = 1'b0;
        end else begin
          slots_nxt[s].cnt = slots[s].cnt - DELAY_W'(1);
        end
      end
    end
    if (hs) begin
      slots_nxt[alloc_idx] = '{vld: 1'b1, evt: sel_evt, cnt: sel_delay};
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      vld_nxt[s] = slots_nxt[s].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slots[s] <= '0;
      end
      evt_fire   <= '0;
      busy       <= 1'b0;
      slots_used <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slots[s] <= slots_nxt[s];
      end
      evt_fire   <= fire_nxt;
      busy       <= |vld_nxt;
      slots_used <= USED_W'(popcount(MAX_SLOTS'(vld_nxt)));
      if (hs) begin
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule
